// File: rtl/stopwatch_ctrl_if.sv
// Display/debug bundle driven by stopwatch_ctrl: seven-segment digits,
// state/overflow LEDs and the live BCD count.
interface stopwatch_ctrl_if;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [2:0]  LEDR;
  logic [11:0] COUNT;

  modport master (output HEX0, HEX1, HEX2, LEDR, COUNT);
  modport slave  (input  HEX0, HEX1, HEX2, LEDR, COUNT);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Three-digit BCD stopwatch: start/stop, lap freeze and clear buttons,
// prescaled tick, sticky wrap flag and active-low seven-segment output.
module seg7_dec (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0011000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic             CLOCK_50,
  input  logic [3:0]       KEY,
  stopwatch_ctrl_if.master disp
);
  localparam int NUM_DIG     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] uni;
  } bcd_t;

  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.uni != 4'd9) r.uni = v.uni + 4'd1;
    else begin
      r.uni = 4'd0;
      if (v.ten != 4'd9) r.ten = v.ten + 4'd1;
      else begin
        r.ten = 4'd0;
        r.hun = (v.hun == 4'd9) ? 4'd0 : v.hun + 4'd1;
      end
    end
    return r;
  endfunction

  logic rst_n;
  assign rst_n = KEY[0];

  // Key bits: [0] start/stop, [1] lap, [2] clear (all active-low)
  logic [2:0]             sync1, sync2, key_q, press_q;
  logic [SYNC_STAGES:0]   vld_pipe;

  // vld_pipe masks edge detection until the chain holds real samples, so a
  // key held through reset release never reads as a fresh press.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '1;
      sync2    <= '1;
      key_q    <= '1;
      press_q  <= '0;
      vld_pipe <= '0;
    end else begin
      sync1    <= KEY[3:1];
      sync2    <= sync1;
      key_q    <= sync2;
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      press_q  <= {3{vld_pipe[SYNC_STAGES]}} & key_q & ~sync2;
    end
  end

  logic ev_ss, ev_lap, ev_clr;
  assign ev_ss  = press_q[0];
  assign ev_lap = press_q[1];
  assign ev_clr = press_q[2];

  logic [1:0]    state, state_nxt;
  logic          do_clear, do_cap;
  logic          running, tick, ovf;
  logic [PW-1:0] presc;
  bcd_t          count, lap_reg, shown;

  always_comb begin
    state_nxt = state;
    do_clear  = 1'b0;
    do_cap    = 1'b0;
    if (ev_clr && (state == S_IDLE || state == S_PAUSE)) begin
      state_nxt = S_IDLE;
      do_clear  = 1'b1;
    end else if (ev_ss) begin
      state_nxt = (state == S_RUN || state == S_LAP) ? S_PAUSE : S_RUN;
    end else if (ev_lap && state == S_RUN) begin
      state_nxt = S_LAP;
      do_cap    = 1'b1;
    end else if (ev_lap && state == S_LAP) begin
      state_nxt = S_RUN;
    end
  end

  assign running = (state == S_RUN) || (state == S_LAP);
  assign tick    = running && (presc == PW'(TICK_DIV - 1));

  // Tick is judged on the current state, so a tick coinciding with a
  // pause or lap capture still counts and the capture sees the old value.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      presc   <= '0;
      count   <= '0;
      lap_reg <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_clear) begin
        presc   <= '0;
        count   <= '0;
        lap_reg <= '0;
        ovf     <= 1'b0;
      end else begin
        if (running) presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          count <= bcd_inc(count);
          if (count == 12'h999) ovf <= 1'b1;
        end
        if (do_cap) lap_reg <= count;
      end
    end
  end

  assign shown = (state == S_LAP) ? lap_reg : count;

  logic [NUM_DIG-1:0][3:0] digits;
  logic [NUM_DIG-1:0][6:0] segs;
  assign digits = {shown.hun, shown.ten, shown.uni};

  genvar i;
  generate
    for (i = 0; i < NUM_DIG; i++) begin : g_dig
      seg7_dec u_dec (.digit(digits[i]), .seg(segs[i]));
    end
  endgenerate

  assign disp.HEX0  = segs[0];
  assign disp.HEX1  = segs[1];
  assign disp.HEX2  = segs[2];
  assign disp.LEDR  = {ovf, state};
  assign disp.COUNT = count;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch bench: behavioural model feeds a scoreboard queue checked every
// cycle, plus directed checks for wrap, lap freeze, clear priority and reset.
module tb_stopwatch_ctrl;
  localparam int TD = 4;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'b1110;
  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (.CLOCK_50(CLOCK_50), .KEY(KEY), .disp(sw));

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000};

  // Model: states 0 idle, 1 run, 2 pause, 3 lap; count kept as an integer
  int m_st = 0, m_cnt = 0, m_lap = 0, m_ovf = 0, m_presc = 0;
  logic [2:0] kh [$];
  logic [35:0] sb [$];

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [35:0] expv();
    int d;
    d = (m_st == 3) ? m_lap : m_cnt;
    return {seg_tab[d / 100], seg_tab[(d / 10) % 10], seg_tab[d % 10],
            m_ovf[0], m_st[1:0], to_bcd(m_cnt)};
  endfunction

  function automatic logic [35:0] actv();
    return {sw.HEX2, sw.HEX1, sw.HEX0, sw.LEDR, sw.COUNT};
  endfunction

  // A press acts 3 edges after its first low sample, and only once a high
  // sample has been seen after reset release.
  always @(posedge CLOCK_50) begin
    logic [2:0] ev;
    int old_cnt;
    logic run, tk;
    if (!KEY[0]) begin
      m_st = 0; m_cnt = 0; m_lap = 0; m_ovf = 0; m_presc = 0;
      kh.delete();
    end else begin
      kh.push_front(KEY[3:1]);
      if (kh.size() > 5) void'(kh.pop_back());
      ev = 3'b000;
      if (kh.size() == 5)
        for (int k = 0; k < 3; k++) ev[k] = !kh[3][k] && kh[4][k];
      run = (m_st == 1) || (m_st == 3);
      tk = run && (m_presc == TD - 1);
      old_cnt = m_cnt;
      if (run) m_presc = tk ? 0 : m_presc + 1;
      if (tk) begin
        if (m_cnt == 999) m_ovf = 1;
        m_cnt = (m_cnt + 1) % 1000;
      end
      if (ev[2] && (m_st == 0 || m_st == 2)) begin
        m_st = 0; m_cnt = 0; m_presc = 0; m_lap = 0; m_ovf = 0;
      end else if (ev[0]) m_st = run ? 2 : 1;
      else if (ev[1] && m_st == 1) begin m_st = 3; m_lap = old_cnt; end
      else if (ev[1] && m_st == 3) m_st = 1;
    end
    sb.push_back(expv());
  end

  always @(posedge CLOCK_50) begin
    logic [35:0] e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (actv() !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got hex=%h_%h_%h ledr=%b cnt=%h, expected hex=%h_%h_%h ledr=%b cnt=%h",
                 $time, sw.HEX2, sw.HEX1, sw.HEX0, sw.LEDR, sw.COUNT,
                 e[35:29], e[28:22], e[21:15], e[14:12], e[11:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press(input int k, input int hold);
    KEY[k] = 1'b0;
    cyc(hold);
    KEY[k] = 1'b1;
    cyc(4);
  endtask

  task automatic wait_cnt(input int c, input int p, input string nm);
    int i;
    i = 0;
    while (!(m_cnt == c && (p < 0 || m_presc == p)) && i < 6000) begin
      @(negedge CLOCK_50);
      i++;
    end
    if (!(m_cnt == c && (p < 0 || m_presc == p))) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout, model count %0d expected %0d", nm, m_cnt, c);
    end
  endtask

  localparam logic [20:0] HEX_RST = {7'b1000000, 7'b1000000, 7'b1000000};

  initial begin
    cyc(3);
    KEY[0] = 1'b1;
    cyc(5);

    // start, first count after 4 cycles, 010 after 40
    KEY[1] = 1'b0; cyc(1); KEY[1] = 1'b1; cyc(3);
    chk("start_state", {21'd0, sw.LEDR, sw.COUNT}, {21'd0, 3'b001, 12'h000});
    cyc(4);
    chk("first_tick", {24'd0, sw.COUNT}, {24'd0, 12'h001});
    cyc(36);
    chk("count_010", {24'd0, sw.COUNT}, {24'd0, 12'h010});

    // wrap past 999
    wait_cnt(999, -1, "reach_999");
    wait_cnt(0, -1, "wrap_000");
    chk("wrap", {21'd0, sw.LEDR, sw.COUNT}, {21'd0, 3'b101, 12'h000});
    press(1, 2);
    chk("pause", {34'd0, sw.LEDR[1:0]}, {34'd0, 2'b10});
    press(3, 1);
    chk("clear", {21'd0, sw.LEDR, sw.COUNT}, 36'd0);

    // lap freeze at 012
    press(1, 1);
    wait_cnt(11, 1, "reach_011");
    press(2, 1);
    chk("lap_hex", {15'd0, sw.HEX2, sw.HEX1, sw.HEX0},
        {15'd0, 7'b1000000, 7'b1111001, 7'b0100100});
    cyc(20);
    chk("lap_frozen", {15'd0, sw.HEX2, sw.HEX1, sw.HEX0},
        {15'd0, 7'b1000000, 7'b1111001, 7'b0100100});
    chk("lap_counting", {24'd0, sw.COUNT}, {24'd0, to_bcd(m_cnt)});
    press(2, 2);
    chk("lap_exit", {34'd0, sw.LEDR[1:0]}, {34'd0, 2'b01});

    // clear ignored in RUN; clear beats start/stop in PAUSE
    press(3, 1);
    chk("clear_in_run", {34'd0, sw.LEDR[1:0]}, {34'd0, 2'b01});
    press(1, 1);
    KEY[3] = 1'b0; KEY[1] = 1'b0; cyc(1); KEY[3] = 1'b1; KEY[1] = 1'b1; cyc(4);
    chk("clear_priority", {21'd0, sw.LEDR, sw.COUNT}, 36'd0);

    // random single-key traffic checked by the scoreboard
    for (int r = 0; r < 60; r++) begin
      press($urandom_range(1, 3), $urandom_range(1, 4));
      cyc($urandom_range(0, 12));
    end

    // tick coincident with lap capture at 019
    KEY[0] = 1'b0; cyc(2); KEY[0] = 1'b1; cyc(5);
    press(1, 2);
    wait_cnt(19, 0, "reach_019");
    press(2, 1);
    chk("lap_tick_hex", {15'd0, sw.HEX2, sw.HEX1, sw.HEX0},
        {15'd0, 7'b1000000, 7'b1111001, 7'b0011000});
    chk("lap_tick_cnt", {21'd0, sw.LEDR, sw.COUNT}, {21'd0, 3'b011, 12'h020});

    // async reset mid-LAP at 057, start held through release
    wait_cnt(57, -1, "reach_057");
    #1 KEY[0] = 1'b0;
    #1 chk("async_reset", actv(), {HEX_RST, 3'b000, 12'h000});
    KEY[1] = 1'b0;
    cyc(2);
    KEY[0] = 1'b1;
    cyc(10);
    chk("held_key_no_start", {21'd0, sw.LEDR, sw.COUNT}, 36'd0);
    KEY[1] = 1'b1;
    cyc(3);
    press(1, 1);
    chk("restart", {34'd0, sw.LEDR[1:0]}, {34'd0, 2'b01});

    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 expected completion");
    $fatal(1);
  end
endmodule
